uart_host_ctrl: RTL and testbench

Hardware host-side sequencer for the system UART console protocol. It drives an iob-uart native slave bus to configure the UART, poll and read received characters, and reply to the target's connect/file-transfer requests (ENQ, EOT, FRX, FTX). It replaces the behavioural CPU tasks in system-level benches and FPGA host loops, forwarding console characters and streaming firmware files in and out.

---
 rtl/uart_host_ctrl.sv | 230 +++++++++++++++++++++++
 tb/tb_uart_host_ctrl.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_host_ctrl.sv
// ============================================================================
//  uart_host_ctrl : host-side UART console sequencer (init, console, file I/O)
//  Revision 1.0   : initial release
// ============================================================================
`default_nettype none

module uart_host_ctrl #(
  parameter int UART_ADDR_W = 3,
  parameter int DATA_W      = 32,
  parameter int DIV         = 868,
  parameter int A_DIV       = 1,
  parameter int A_TXEN      = 2,
  parameter int A_RXEN      = 3,
  parameter int A_TXREADY   = 4,
  parameter int A_RXREADY   = 5,
  parameter int A_TXDATA    = 6,
  parameter int A_RXDATA    = 7
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   ld_fw,
  output logic                   uart_valid,
  output logic [UART_ADDR_W-1:0] uart_addr,
  output logic [DATA_W-1:0]      uart_wdata,
  output logic [3:0]             uart_wstrb,
  input  logic [DATA_W-1:0]      uart_rdata,
  input  logic                   uart_ready,
  input  logic [31:0]            tx_size,
  output logic [31:0]            tx_addr,
  input  logic [7:0]             tx_byte,
  output logic                   rx_valid,
  output logic [31:0]            rx_addr,
  output logic [7:0]             rx_byte,
  output logic                   char_valid,
  output logic [7:0]             char,
  output logic                   connected,
  output logic                   busy,
  output logic                   done
);

  localparam logic [3:0] S_IDLE     = 4'd0;
  localparam logic [3:0] S_CFG_DIV  = 4'd1;
  localparam logic [3:0] S_CFG_TXEN = 4'd2;
  localparam logic [3:0] S_CFG_RXEN = 4'd3;
  localparam logic [3:0] S_POLL_RX  = 4'd4;
  localparam logic [3:0] S_READ_RX  = 4'd5;
  localparam logic [3:0] S_DISPATCH = 4'd6;
  localparam logic [3:0] S_POLL_TX  = 4'd7;
  localparam logic [3:0] S_WRITE_TX = 4'd8;
  localparam logic [3:0] S_SZ_TX    = 4'd9;
  localparam logic [3:0] S_DAT_TX   = 4'd10;
  localparam logic [3:0] S_SZ_RX    = 4'd11;
  localparam logic [3:0] S_DAT_RX   = 4'd12;
  localparam logic [3:0] S_DONE     = 4'd13;

  localparam logic [7:0] C_ENQ = 8'h05;
  localparam logic [7:0] C_EOT = 8'h04;
  localparam logic [7:0] C_ACK = 8'h06;
  localparam logic [7:0] C_FRX = 8'h07;
  localparam logic [7:0] C_FTX = 8'h08;

  // Where a received byte is routed after READ_RX
  localparam logic [1:0] M_CON = 2'd0;
  localparam logic [1:0] M_SZ  = 2'd1;
  localparam logic [1:0] M_DAT = 2'd2;

  logic [3:0]  r_state, w_next, r_ret;
  logic [1:0]  r_mode;
  logic        r_valid, r_tx_file, r_connected;
  logic [31:0] r_cnt, r_size, r_tx_addr;
  logic [7:0]  r_rx_byte, r_tx_byte;
  logic        w_bus, w_acc, w_is_code;
  logic [31:0] w_size_shift;
  logic [DATA_W-9:0] w_unused_rdata;

  assign w_unused_rdata = uart_rdata[DATA_W-1:8];
  assign w_bus = (r_state inside {S_CFG_DIV, S_CFG_TXEN, S_CFG_RXEN, S_POLL_RX,
                                  S_READ_RX, S_POLL_TX, S_WRITE_TX});
  assign w_acc = w_bus && r_valid && uart_ready;
  assign w_is_code = (r_rx_byte inside {C_ENQ, C_EOT, C_FRX, C_FTX});
  assign w_size_shift = {r_rx_byte, r_size[31:8]};

  always_ff @(posedge clk) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:     if (start) w_next = S_CFG_DIV;
      S_CFG_DIV:  if (w_acc) w_next = S_CFG_TXEN;
      S_CFG_TXEN: if (w_acc) w_next = S_CFG_RXEN;
      S_CFG_RXEN: if (w_acc) w_next = S_POLL_RX;
      S_POLL_RX:  if (w_acc && uart_rdata[0]) w_next = S_READ_RX;
      S_READ_RX:
        if (w_acc) begin
          if (r_mode == M_SZ)       w_next = S_SZ_RX;
          else if (r_mode == M_DAT) w_next = S_DAT_RX;
          else                      w_next = S_DISPATCH;
        end
      S_DISPATCH:
        case (r_rx_byte)
          C_ENQ:   w_next = r_connected ? S_POLL_RX : S_POLL_TX;
          C_EOT:   w_next = S_DONE;
          C_FRX:   w_next = S_SZ_TX;
          default: w_next = S_POLL_RX;
        endcase
      S_SZ_TX:
        if (r_cnt == 32'd4) w_next = (r_size == 32'd0) ? S_POLL_RX : S_DAT_TX;
        else                w_next = S_POLL_TX;
      S_DAT_TX:   w_next = (r_cnt == r_size) ? S_POLL_RX : S_POLL_TX;
      S_POLL_TX:  if (w_acc && uart_rdata[0]) w_next = S_WRITE_TX;
      S_WRITE_TX: if (w_acc) w_next = r_ret;
      S_SZ_RX:    w_next = S_POLL_RX;
      S_DAT_RX:   w_next = S_POLL_RX;
      S_DONE:     w_next = S_DONE;
      default:    w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_valid     <= 1'b0;
      r_mode      <= M_CON;
      r_ret       <= S_POLL_RX;
      r_tx_file   <= 1'b0;
      r_connected <= 1'b0;
      r_cnt       <= 32'd0;
      r_size      <= 32'd0;
      r_tx_addr   <= 32'd0;
      r_rx_byte   <= 8'd0;
      r_tx_byte   <= 8'd0;
    end else begin
      // Request rises one cycle after entry and drops right after completion
      if (w_bus && !r_valid)  r_valid <= 1'b1;
      else if (!w_bus || uart_ready) r_valid <= 1'b0;

      case (r_state)
        S_READ_RX: if (w_acc) r_rx_byte <= uart_rdata[7:0];
        S_POLL_TX: if (w_acc && uart_rdata[0] && r_tx_file) r_tx_byte <= tx_byte;
        S_DISPATCH:
          case (r_rx_byte)
            C_ENQ:
              if (!r_connected) begin
                r_connected <= 1'b1;
                r_tx_byte   <= ld_fw ? C_FRX : C_ACK;
                r_ret       <= S_POLL_RX;
                r_tx_file   <= 1'b0;
              end
            C_FRX: begin
              r_size <= tx_size;
              r_cnt  <= 32'd0;
            end
            C_FTX: begin
              r_mode <= M_SZ;
              r_size <= 32'd0;
              r_cnt  <= 32'd0;
            end
            default: ;
          endcase
        S_SZ_TX:
          if (r_cnt == 32'd4) begin
            r_cnt <= 32'd0;
          end else begin
            // Rotating keeps the full size intact after all four bytes
            r_tx_byte <= r_size[7:0];
            r_size    <= {r_size[7:0], r_size[31:8]};
            r_cnt     <= r_cnt + 32'd1;
            r_ret     <= S_SZ_TX;
            r_tx_file <= 1'b0;
          end
        S_DAT_TX:
          if (r_cnt != r_size) begin
            r_tx_addr <= r_cnt;
            r_cnt     <= r_cnt + 32'd1;
            r_ret     <= S_DAT_TX;
            r_tx_file <= 1'b1;
          end
        S_SZ_RX: begin
          r_size <= w_size_shift;
          if (r_cnt == 32'd3) begin
            r_cnt  <= 32'd0;
            r_mode <= (w_size_shift == 32'd0) ? M_CON : M_DAT;
          end else begin
            r_cnt <= r_cnt + 32'd1;
          end
        end
        S_DAT_RX:
          if (r_cnt + 32'd1 == r_size) begin
            r_cnt  <= 32'd0;
            r_mode <= M_CON;
          end else begin
            r_cnt <= r_cnt + 32'd1;
          end
        default: ;
      endcase
    end
  end

  always_comb begin
    uart_valid = r_valid;
    uart_addr  = '0;
    uart_wdata = '0;
    uart_wstrb = 4'h0;
    case (r_state)
      S_CFG_DIV:  begin uart_addr = UART_ADDR_W'(A_DIV);  uart_wdata = DATA_W'(DIV); uart_wstrb = 4'hF; end
      S_CFG_TXEN: begin uart_addr = UART_ADDR_W'(A_TXEN); uart_wdata = DATA_W'(1);   uart_wstrb = 4'hF; end
      S_CFG_RXEN: begin uart_addr = UART_ADDR_W'(A_RXEN); uart_wdata = DATA_W'(1);   uart_wstrb = 4'hF; end
      S_POLL_RX:  uart_addr = UART_ADDR_W'(A_RXREADY);
      S_READ_RX:  uart_addr = UART_ADDR_W'(A_RXDATA);
      S_POLL_TX:  uart_addr = UART_ADDR_W'(A_TXREADY);
      S_WRITE_TX: begin uart_addr = UART_ADDR_W'(A_TXDATA); uart_wdata = DATA_W'(r_tx_byte); uart_wstrb = 4'h1; end
      default: ;
    endcase
    char_valid = (r_state == S_DISPATCH) && !w_is_code;
    char       = char_valid ? r_rx_byte : 8'd0;
    rx_valid   = (r_state == S_DAT_RX);
    rx_addr    = rx_valid ? r_cnt : 32'd0;
    rx_byte    = rx_valid ? r_rx_byte : 8'd0;
    tx_addr    = r_tx_addr;
    connected  = r_connected;
    done       = (r_state == S_DONE);
    busy       = (r_state != S_IDLE) && (r_state != S_DONE);
  end

endmodule

`default_nettype wire

// File: tb/tb_uart_host_ctrl.sv
// ============================================================================
//  tb_uart_host_ctrl : directed bench with a behavioural UART slave model
//  Revision 1.0      : initial release
// ============================================================================
`default_nettype none

module tb_uart_host_ctrl;
  localparam logic [2:0] A_DIV = 3'd1, A_TXEN = 3'd2, A_RXEN = 3'd3, A_TXREADY = 3'd4,
                         A_RXREADY = 3'd5, A_TXDATA = 3'd6, A_RXDATA = 3'd7;

  logic        clk = 1'b0, reset = 1'b0, start = 1'b0, ld_fw = 1'b0;
  logic        uart_valid, uart_ready = 1'b0;
  logic [2:0]  uart_addr;
  logic [31:0] uart_wdata, uart_rdata = 32'd0;
  logic [3:0]  uart_wstrb;
  logic [31:0] tx_size = 32'd0, tx_addr, rx_addr;
  logic [7:0]  tx_byte, rx_byte, char;
  logic        rx_valid, char_valid, connected, busy, done;

  uart_host_ctrl dut (
    .clk(clk), .reset(reset), .start(start), .ld_fw(ld_fw),
    .uart_valid(uart_valid), .uart_addr(uart_addr), .uart_wdata(uart_wdata),
    .uart_wstrb(uart_wstrb), .uart_rdata(uart_rdata), .uart_ready(uart_ready),
    .tx_size(tx_size), .tx_addr(tx_addr), .tx_byte(tx_byte),
    .rx_valid(rx_valid), .rx_addr(rx_addr), .rx_byte(rx_byte),
    .char_valid(char_valid), .char(char),
    .connected(connected), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  logic [7:0] file_mem [16];
  assign tx_byte = file_mem[tx_addr[3:0]];

  typedef struct packed { logic [2:0] a; logic [31:0] d; logic [3:0] s; } wr_t;
  wr_t        wr_log[$];
  logic [7:0] tx_log[$], rxq[$], char_q[$];
  logic [39:0] rx_q[$];
  int delay = 0, wcnt = 0, txpoll_n = 0, drop_n = 0;
  logic prev_valid = 1'b0;

  // Slave: answers after `delay` extra cycles, one-cycle ready
  always @(negedge clk) begin
    if (!reset) begin
      uart_ready = 1'b0; wcnt = 0; prev_valid = 1'b0;
    end else begin
      if (prev_valid && !uart_valid && !uart_ready) drop_n++;
      prev_valid = uart_valid;
      if (uart_ready) uart_ready = 1'b0;
      else if (!uart_valid) wcnt = 0;
      else if (wcnt < delay) wcnt++;
      else begin
        wcnt = 0; uart_ready = 1'b1; uart_rdata = 32'd0;
        if (uart_wstrb != 4'h0) begin
          wr_log.push_back('{uart_addr, uart_wdata, uart_wstrb});
          if (uart_addr == A_TXDATA) tx_log.push_back(uart_wdata[7:0]);
        end else begin
          case (uart_addr)
            A_RXREADY: uart_rdata = {31'd0, rxq.size() != 0};
            A_RXDATA:  uart_rdata = {24'd0, rxq.pop_front()};
            A_TXREADY: begin uart_rdata = 32'd1; txpoll_n++; end
            default: ;
          endcase
        end
      end
    end
  end

  always @(negedge clk) begin
    if (reset && char_valid) char_q.push_back(char);
    if (reset && rx_valid)   rx_q.push_back({rx_addr, rx_byte});
  end

  int n_chk = 0, n_err = 0;
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1; @(negedge clk); start = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0; repeat (2) @(negedge clk); reset = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_init(input string tag);
    int i;
    for (i = 0; i < 400 && wr_log.size() < 3; i++) @(negedge clk);
    check(tag, i < 400, 1);
    idle(20);
  endtask

  logic [7:0] exp_tx [7];

  initial begin
    exp_tx = '{8'h03, 8'h00, 8'h00, 8'h00, 8'hAA, 8'hBB, 8'hCC};
    for (int i = 0; i < 16; i++) file_mem[i] = 8'h00;
    file_mem[0] = 8'hAA; file_mem[1] = 8'hBB; file_mem[2] = 8'hCC;
    @(negedge clk);
    do_reset();
    check("rst_valid", uart_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_conn", connected, 0);
    check("rst_txaddr", tx_addr, 0);

    // Init with slow slave, plus start-to-valid latency
    delay = 3; drop_n = 0;
    pulse_start();
    check("lat_c1_valid", uart_valid, 0);
    check("busy_cfg", busy, 1);
    @(negedge clk);
    check("lat_c2_valid", uart_valid, 1);
    wait_init("init3_to");
    check("init3_n", wr_log.size(), 3);
    check("init3_w0", wr_log[0], {A_DIV, 32'd868, 4'hF});
    check("init3_w1", wr_log[1], {A_TXEN, 32'd1, 4'hF});
    check("init3_w2", wr_log[2], {A_RXEN, 32'd1, 4'hF});
    check("init3_hold", drop_n, 0);

    // Reset in the middle of the TXEN access
    do_reset(); wr_log.delete();
    pulse_start();
    for (int i = 0; i < 100 && !(uart_valid && uart_addr == A_TXEN); i++) @(negedge clk);
    check("txen_seen", uart_valid && uart_addr == A_TXEN, 1);
    reset = 1'b0; @(negedge clk);
    check("midrst_valid", uart_valid, 0);
    check("midrst_busy", busy, 0);
    @(negedge clk); reset = 1'b1;
    delay = 0; wr_log.delete();
    pulse_start(); @(negedge clk);
    check("restart_valid", uart_valid, 1);
    check("restart_addr", uart_addr, A_DIV);
    check("restart_wdata", uart_wdata, 32'd868);
    wait_init("init0_to");

    // Console characters
    rxq.push_back(8'h48); rxq.push_back(8'h69);
    for (int i = 0; i < 300 && char_q.size() < 2; i++) @(negedge clk);
    check("char_n", char_q.size(), 2);
    check("char0", char_q[0], 8'h48);
    check("char1", char_q[1], 8'h69);

    // ENQ with ld_fw=0, then a second ENQ that must be ignored
    ld_fw = 1'b0; tx_log.delete(); txpoll_n = 0;
    rxq.push_back(8'h05);
    for (int i = 0; i < 300 && tx_log.size() < 1; i++) @(negedge clk);
    check("ack_n", tx_log.size(), 1);
    check("ack_wr", wr_log[wr_log.size()-1], {A_TXDATA, 32'h06, 4'h1});
    check("conn", connected, 1);
    ld_fw = 1'b1; rxq.push_back(8'h05);
    for (int i = 0; i < 300 && rxq.size() != 0; i++) @(negedge clk);
    idle(60);
    check("enq2_n", tx_log.size(), 1);
    check("enq_polls", txpoll_n, 1);
    check("enq2_char", char_q.size(), 2);

    // FRX: send size then file bytes
    tx_size = 32'd3; tx_log.delete(); txpoll_n = 0;
    rxq.push_back(8'h07);
    for (int i = 0; i < 1000 && tx_log.size() < 7; i++) @(negedge clk);
    idle(40);
    check("frx_n", tx_log.size(), 7);
    for (int i = 0; i < 7; i++) check($sformatf("frx_b%0d", i), tx_log[i], exp_tx[i]);
    check("frx_polls", txpoll_n, 7);

    // FTX: 2 data bytes, then an empty file followed by a console char
    rxq = '{8'h08, 8'h02, 8'h00, 8'h00, 8'h00, 8'h5A, 8'hA5};
    for (int i = 0; i < 1000 && rx_q.size() < 2; i++) @(negedge clk);
    check("ftx_n", rx_q.size(), 2);
    check("ftx_0", rx_q[0], {32'd0, 8'h5A});
    check("ftx_1", rx_q[1], {32'd1, 8'hA5});
    rxq = '{8'h08, 8'h00, 8'h00, 8'h00, 8'h00, 8'h21};
    for (int i = 0; i < 1000 && char_q.size() < 3; i++) @(negedge clk);
    check("ftx0_char_n", char_q.size(), 3);
    check("ftx0_char", char_q[2], 8'h21);
    check("ftx0_rx_n", rx_q.size(), 2);

    // EOT terminates; start is ignored afterwards
    rxq.push_back(8'h04);
    for (int i = 0; i < 300 && !done; i++) @(negedge clk);
    check("eot_done", done, 1);
    check("eot_busy", busy, 0);
    pulse_start(); idle(5);
    check("done_hold", done, 1);
    check("done_valid", uart_valid, 0);
    check("eot_char_n", char_q.size(), 3);
    do_reset();
    check("rst2_done", done, 0);
    check("rst2_conn", connected, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
